// File: rtl/qpsk_llr_demapper_pkg.sv
// Shared constants and FSM state type for the BPSK/QPSK soft-demapper family.
package qpsk_llr_demapper_pkg;

    localparam int LLR_W   = 6;
    localparam int N_SYM   = 432;
    localparam int LLR_SAT = (1 << (LLR_W - 1)) - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_I = 2'd1,
        SEND_Q = 2'd2
    } demap_state_t;

endpackage

// File: rtl/qpsk_llr_demapper_llr_scale_sat.sv
// One LLR lane: signed component times unsigned scale, arithmetic shift, then
// symmetric saturation so the most negative code never appears.
module llr_scale_sat
#(
    parameter int IN_W    = 8,
    parameter int SCALE_W = 8,
    parameter int SHIFT   = 4,
    parameter int LLR_W   = 6
)
(
    input  logic signed [IN_W-1:0]    x,
    input  logic        [SCALE_W-1:0] scale,
    output logic signed [LLR_W-1:0]   y
);
    import qpsk_llr_demapper_pkg::*;

    localparam int PW  = IN_W + SCALE_W + 1;
    localparam int SAT = (1 << (LLR_W - 1)) - 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'(SAT);
    localparam logic signed [PW-1:0] SAT_LO = -SAT_HI;

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    // The scale is zero-extended so it always acts as a non-negative factor.
    assign x_ext   = {{(PW - IN_W){x[IN_W-1]}}, x};
    assign s_ext   = {{(PW - SCALE_W){1'b0}}, scale};
    assign prod    = x_ext * s_ext;
    assign shifted = prod >>> SHIFT;

    always_comb begin
        y = shifted[LLR_W-1:0];
        if (shifted > SAT_HI) begin
            y = SAT_HI[LLR_W-1:0];
        end else if (shifted < SAT_LO) begin
            y = SAT_LO[LLR_W-1:0];
        end
    end

endmodule

// File: rtl/qpsk_llr_demapper.sv
// Soft QPSK demapper: one I/Q symbol in, two saturated LLRs out (I then Q),
// with a block-last flag on the final LLR of every N_SYM-symbol block.
module qpsk_llr_demapper
#(
    parameter int FP      = 16,
    parameter int SCALE_W = 8,
    parameter int SHIFT   = 4,
    parameter int LLR_W   = 6,
    parameter int N_SYM   = 432
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [FP/2-1:0]    in_i,
    input  logic signed [FP/2-1:0]    in_q,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic        [SCALE_W-1:0] scale,
    output logic signed [LLR_W-1:0]   llr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic        [1:0]         state_dbg
);
    import qpsk_llr_demapper_pkg::*;

    localparam int CNT_W = $clog2(N_SYM);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and held data stays stable.

    demap_state_t state_q;
    demap_state_t state_d;

    logic signed [LLR_W-1:0] llr_i_new;
    logic signed [LLR_W-1:0] llr_q_new;
    logic signed [LLR_W-1:0] llr_i_r;
    logic signed [LLR_W-1:0] llr_q_r;
    logic        [CNT_W-1:0] sym_cnt;
    logic                    accept;
    logic                    q_done;
    logic                    cnt_at_last;

    llr_scale_sat #(
        .IN_W    (FP/2),
        .SCALE_W (SCALE_W),
        .SHIFT   (SHIFT),
        .LLR_W   (LLR_W)
    ) u_lane_i (
        .x     (in_i),
        .scale (scale),
        .y     (llr_i_new)
    );

    llr_scale_sat #(
        .IN_W    (FP/2),
        .SCALE_W (SCALE_W),
        .SHIFT   (SHIFT),
        .LLR_W   (LLR_W)
    ) u_lane_q (
        .x     (in_q),
        .scale (scale),
        .y     (llr_q_new)
    );

    assign cnt_at_last = (sym_cnt == CNT_W'(N_SYM - 1));
    assign state_dbg   = state_q;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        q_done   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SEND_I;
                end
            end
            SEND_I: begin
                if (out_ready) begin
                    state_d = SEND_Q;
                end
            end
            SEND_Q: begin
                // Q going out frees the lane registers, so a new symbol can
                // land in the same cycle and the stream stays gap-free.
                in_ready = out_ready;
                if (out_ready) begin
                    q_done = 1'b1;
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = SEND_I;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llr_i_r <= '0;
            llr_q_r <= '0;
        end else if (accept) begin
            llr_i_r <= llr_i_new;
            llr_q_r <= llr_q_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt <= '0;
        end else if (q_done) begin
            sym_cnt <= cnt_at_last ? '0 : sym_cnt + CNT_W'(1);
        end
    end

    // Outputs are loaded from the next state so they line up with state_q.
    // The counter only moves when leaving SEND_Q, so on entry to SEND_Q it
    // still holds the index of the symbol being sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llr       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state_d)
                SEND_I: begin
                    llr       <= accept ? llr_i_new : llr_i_r;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                end
                SEND_Q: begin
                    llr       <= llr_q_r;
                    out_valid <= 1'b1;
                    out_last  <= cnt_at_last;
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
